// File: rtl/gpio_cmd_ctrl_if.sv
// GPIO bus between the MicroBlaze GPIO block and the command controller.
// The MicroBlaze side drives the command payload, code and strobe.
// The controller side returns the status / readback word.
interface gpio_cmd_ctrl_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] i_GPIOdata;
  logic [2:0]        i_GPIOctrl;
  logic              i_GPIOvalid;
  logic [31:0]       o_GPIOdata;

  modport master (output i_GPIOdata, i_GPIOctrl, i_GPIOvalid, input o_GPIOdata);
  modport slave  (input i_GPIOdata, i_GPIOctrl, i_GPIOvalid, output o_GPIOdata);
endinterface

// File: rtl/gpio_cmd_ctrl.sv
// GPIO command decoder and control register file for the convolution
// accelerator. It turns edge-strobed GPIO commands into kernel and pixel
// writes, holds the image length, and sequences IDLE/LOAD/RUN/DONE.
// A sticky error flag records any command that is illegal in the current state.
module gpio_cmd_ctrl #(
  parameter int DATA_W    = 24,
  parameter int PIX_W     = 8,
  parameter int MCU_W     = 13,
  parameter int LEN_W     = 10,
  parameter int KNL_WORDS = 3,
  parameter int KI_W      = $clog2(KNL_WORDS)
) (
  input  logic              i_CLK,
  input  logic              i_rst,
  gpio_cmd_ctrl_if.slave    gpio,
  input  logic [MCU_W-1:0]  i_MCUdata,
  input  logic              i_EOP_from_FSM,
  output logic [DATA_W-1:0] o_KNLdata,
  output logic [KI_W-1:0]   o_KNLidx,
  output logic              o_valid_to_CONV,
  output logic [PIX_W-1:0]  o_MCUdata,
  output logic              o_valid_to_FSM,
  output logic [LEN_W-1:0]  o_imgLength,
  output logic              o_load,
  output logic              o_run,
  output logic              o_KNorIMG,
  output logic              o_EOP_to_MCU
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  localparam logic [2:0] CMD_KNL  = 3'd0;
  localparam logic [2:0] CMD_SIZE = 3'd1;
  localparam logic [2:0] CMD_IMG  = 3'd2;
  localparam logic [2:0] CMD_REQ  = 3'd3;
  localparam logic [2:0] CMD_RUN  = 3'd4;
  localparam logic [2:0] CMD_ACK  = 3'd5;

  localparam logic [KI_W-1:0] KCNT_LAST = KI_W'(KNL_WORDS - 1);

  state_e              state_q, state_d;
  logic                valid_q;
  logic                err_q;
  logic                knl_full_q;
  logic [KI_W-1:0]     kcnt_q;
  logic [DATA_W-1:0]   knl_data_q;
  logic [KI_W-1:0]     knl_idx_q;
  logic                knl_vld_q;
  logic [PIX_W-1:0]    pix_q;
  logic                fsm_vld_q;
  logic [LEN_W-1:0]    img_len_q;
  logic                load_q, run_q, eop_q;
  logic [MCU_W-1:0]    rd_q;
  logic [31:0]         gpio_word;

  logic                stb;
  logic                run_ok;
  logic [2:0]          cmd;

  // A level-held valid produces exactly one command on its rising edge.
  assign stb    = gpio.i_GPIOvalid & ~valid_q;
  assign cmd    = gpio.i_GPIOctrl;
  assign run_ok = knl_full_q && (img_len_q != '0);

  // Next-state decode; the state register and all outputs live in one always_ff.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (stb && cmd == CMD_IMG)           state_d = ST_LOAD;
        else if (stb && cmd == CMD_RUN && run_ok) state_d = ST_RUN;
      end
      ST_LOAD: begin
        if (stb && cmd == CMD_RUN && run_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_EOP_from_FSM) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (stb && cmd == CMD_ACK)      state_d = ST_IDLE;
        else if (stb && cmd == CMD_IMG) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register, command execution and registered outputs.
  always_ff @(posedge i_CLK or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      knl_full_q <= 1'b0;
      kcnt_q     <= '0;
      knl_data_q <= '0;
      knl_idx_q  <= '0;
      knl_vld_q  <= 1'b0;
      pix_q      <= '0;
      fsm_vld_q  <= 1'b0;
      img_len_q  <= '0;
      load_q     <= 1'b0;
      run_q      <= 1'b0;
      eop_q      <= 1'b0;
      rd_q       <= '0;
    end else begin
      // NOTE: non-blocking everywhere here so every register samples pre-edge values.
      valid_q   <= gpio.i_GPIOvalid;
      rd_q      <= i_MCUdata;
      knl_vld_q <= 1'b0;
      fsm_vld_q <= 1'b0;
      state_q   <= state_d;
      load_q    <= (state_d == ST_LOAD);
      run_q     <= (state_d == ST_RUN);
      eop_q     <= (state_d == ST_DONE);

      if (state_q == ST_RUN) begin
        // Commands are not accepted while the datapath runs, even alongside EOP.
        if (stb) err_q <= 1'b1;
      end else if (stb) begin
        case (cmd)
          CMD_KNL: begin
            if (state_q == ST_IDLE) begin
              knl_data_q <= gpio.i_GPIOdata;
              knl_idx_q  <= kcnt_q;
              knl_vld_q  <= 1'b1;
              if (kcnt_q == KCNT_LAST) begin
                knl_full_q <= 1'b1;
                kcnt_q     <= '0;
              end else begin
                kcnt_q <= kcnt_q + 1'b1;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
          CMD_SIZE: begin
            if (state_q != ST_DONE && gpio.i_GPIOdata[LEN_W-1:0] != '0)
              img_len_q <= gpio.i_GPIOdata[LEN_W-1:0];
            else
              err_q <= 1'b1;
          end
          CMD_IMG: begin
            // In IDLE and DONE an IMG only enters LOAD; pixels flow once in LOAD.
            if (state_q == ST_LOAD) begin
              pix_q     <= gpio.i_GPIOdata[PIX_W-1:0];
              fsm_vld_q <= 1'b1;
            end
          end
          CMD_REQ: begin
            if (state_q == ST_DONE) fsm_vld_q <= 1'b1;
            else                    err_q     <= 1'b1;
          end
          CMD_RUN: begin
            if (state_q == ST_DONE || !run_ok) err_q <= 1'b1;
          end
          CMD_ACK: err_q <= 1'b0;
          default: err_q <= 1'b1;
        endcase
      end
    end
  end

  // Status word assembled from registers only, so no input reaches it combinationally.
  always_comb begin
    gpio_word              = '0;
    gpio_word[31:30]       = state_q;
    gpio_word[29]          = err_q;
    gpio_word[28]          = knl_full_q;
    gpio_word[27]          = eop_q;
    gpio_word[MCU_W-1:0]   = rd_q;
  end

  assign gpio.o_GPIOdata = gpio_word;
  assign o_KNLdata       = knl_data_q;
  assign o_KNLidx        = knl_idx_q;
  assign o_valid_to_CONV = knl_vld_q;
  assign o_MCUdata       = pix_q;
  assign o_valid_to_FSM  = fsm_vld_q;
  assign o_imgLength     = img_len_q;
  assign o_load          = load_q;
  assign o_run           = run_q;
  assign o_KNorIMG       = run_q;
  assign o_EOP_to_MCU    = eop_q;

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// Directed testbench for gpio_cmd_ctrl with default parameters.
module tb_gpio_cmd_ctrl;

  logic        clk;
  logic        rst;
  logic [12:0] mcu_in;
  logic        eop_in;
  logic [23:0] knl_data;
  logic [1:0]  knl_idx;
  logic        v_conv;
  logic [7:0]  mcu_out;
  logic        v_fsm;
  logic [9:0]  img_len;
  logic        load, run, knorimg, eop_out;

  int vectors;
  int miscompares;

  // Snapshot one cycle after the strobe edge, and one cycle later again.
  logic [31:0] c_gpio;
  logic        c_conv, c_fsm, c_load, c_run, c_kn, c_eop;
  logic [1:0]  c_idx;
  logic [23:0] c_kdat;
  logic [7:0]  c_mcu;
  logic [9:0]  c_len;
  logic        a_conv, a_fsm;

  gpio_cmd_ctrl_if #(.DATA_W(24)) gif ();

  gpio_cmd_ctrl dut (
    .i_CLK          (clk),
    .i_rst          (rst),
    .gpio           (gif),
    .i_MCUdata      (mcu_in),
    .i_EOP_from_FSM (eop_in),
    .o_KNLdata      (knl_data),
    .o_KNLidx       (knl_idx),
    .o_valid_to_CONV(v_conv),
    .o_MCUdata      (mcu_out),
    .o_valid_to_FSM (v_fsm),
    .o_imgLength    (img_len),
    .o_load         (load),
    .o_run          (run),
    .o_KNorIMG      (knorimg),
    .o_EOP_to_MCU   (eop_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic capture();
    c_gpio = gif.o_GPIOdata; c_conv = v_conv; c_fsm = v_fsm; c_idx = knl_idx;
    c_kdat = knl_data; c_mcu = mcu_out; c_len = img_len; c_load = load;
    c_run = run; c_kn = knorimg; c_eop = eop_out;
  endtask

  // One command: valid rises at a falling edge, sampled after the next rising edge.
  task automatic send(input logic [2:0] code, input logic [23:0] data);
    @(negedge clk);
    gif.i_GPIOctrl = code; gif.i_GPIOdata = data; gif.i_GPIOvalid = 1'b1;
    @(negedge clk);
    capture();
    gif.i_GPIOvalid = 1'b0;
    @(negedge clk);
    a_conv = v_conv; a_fsm = v_fsm;
  endtask

  task automatic test_reset();
    rst = 1'b1; mcu_in = '0; eop_in = 1'b0;
    gif.i_GPIOdata = '0; gif.i_GPIOctrl = '0; gif.i_GPIOvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    capture();
    vectors++; if (c_gpio !== 32'h0) begin miscompares++; $display("FAIL reset_gpio: got %h want %h", c_gpio, 32'h0); end
    vectors++; if ({c_conv, c_fsm, c_load, c_run, c_kn, c_eop} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 000000", {c_conv, c_fsm, c_load, c_run, c_kn, c_eop}); end
    vectors++; if ({c_kdat, c_idx, c_mcu, c_len} !== 44'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {c_kdat, c_idx, c_mcu, c_len}); end
  endtask

  task automatic test_run_no_kernel();
    send(3'd4, 24'h0);
    vectors++; if (c_gpio[31:29] !== 3'b001) begin miscompares++; $display("FAIL run_nokernel_state_err: got %b want 001", c_gpio[31:29]); end
    vectors++; if (c_run !== 1'b0) begin miscompares++; $display("FAIL run_nokernel_run: got %b want 0", c_run); end
    send(3'd5, 24'h0);
    vectors++; if (c_gpio[29] !== 1'b0) begin miscompares++; $display("FAIL ack_clear1: got %b want 0", c_gpio[29]); end
  endtask

  task automatic test_illegal();
    send(3'd7, 24'h0);
    vectors++; if (c_gpio[31:29] !== 3'b001) begin miscompares++; $display("FAIL illegal_code: got %b want 001", c_gpio[31:29]); end
    send(3'd5, 24'h0);
  endtask

  task automatic test_kernel();
    logic [23:0] pay [4];
    logic [1:0]  idx [4];
    pay = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    idx = '{2'd0, 2'd1, 2'd2, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send(3'd0, pay[i]);
      vectors++; if (c_conv !== 1'b1 || a_conv !== 1'b0) begin miscompares++; $display("FAIL knl_pulse%0d: got %b%b want 10", i, c_conv, a_conv); end
      vectors++; if (c_idx !== idx[i] || c_kdat !== pay[i]) begin miscompares++; $display("FAIL knl_word%0d: got %0d/%h want %0d/%h", i, c_idx, c_kdat, idx[i], pay[i]); end
      vectors++; if (c_gpio[28] !== (i >= 2)) begin miscompares++; $display("FAIL knl_full%0d: got %b want %b", i, c_gpio[28], (i >= 2)); end
    end
  endtask

  task automatic test_held_valid();
    int pulses;
    logic [1:0] seen_idx;
    pulses = 0; seen_idx = '0;
    @(negedge clk);
    gif.i_GPIOctrl = 3'd0; gif.i_GPIOdata = 24'h555555; gif.i_GPIOvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (v_conv) begin pulses++; seen_idx = knl_idx; end
    end
    gif.i_GPIOvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (v_conv) pulses++;
    end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL held_valid_pulses: got %0d want 1", pulses); end
    vectors++; if (seen_idx !== 2'd1) begin miscompares++; $display("FAIL held_valid_idx: got %0d want 1", seen_idx); end
  endtask

  task automatic test_size();
    send(3'd1, 24'h0);
    vectors++; if (c_gpio[29] !== 1'b1 || c_len !== 10'd0) begin miscompares++; $display("FAIL size_zero: got err=%b len=%0d want err=1 len=0", c_gpio[29], c_len); end
    send(3'd5, 24'h0);
    vectors++; if (c_gpio[29] !== 1'b0) begin miscompares++; $display("FAIL ack_clear2: got %b want 0", c_gpio[29]); end
    send(3'd1, 24'hABC3FF);
    vectors++; if (c_len !== 10'd1023 || c_gpio[29] !== 1'b0) begin miscompares++; $display("FAIL size_3ff: got len=%0d err=%b want 1023/0", c_len, c_gpio[29]); end
  endtask

  task automatic test_image();
    send(3'd2, 24'h00000A);
    vectors++; if (c_load !== 1'b1 || c_gpio[31:30] !== 2'b01 || c_fsm !== 1'b0) begin miscompares++; $display("FAIL img_enter_load: got load=%b st=%b v=%b want 1/01/0", c_load, c_gpio[31:30], c_fsm); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] pix;
      pix = 8'h0B + 8'(i);
      send(3'd2, {16'hFF00, pix});
      vectors++; if (c_fsm !== 1'b1 || a_fsm !== 1'b0 || c_mcu !== pix) begin miscompares++; $display("FAIL img_pixel%0d: got v=%b%b d=%h want 10/%h", i, c_fsm, a_fsm, c_mcu, pix); end
    end
    send(3'd4, 24'h0);
    vectors++; if ({c_run, c_kn, c_load} !== 3'b110 || c_gpio[31:29] !== 3'b100) begin miscompares++; $display("FAIL run_enter: got flags=%b st_err=%b want 110/100", {c_run, c_kn, c_load}, c_gpio[31:29]); end
  endtask

  task automatic test_eop_collision();
    @(negedge clk);
    gif.i_GPIOctrl = 3'd0; gif.i_GPIOdata = 24'h999999; gif.i_GPIOvalid = 1'b1; eop_in = 1'b1;
    @(negedge clk);
    capture();
    gif.i_GPIOvalid = 1'b0; eop_in = 1'b0;
    vectors++; if (c_eop !== 1'b1 || c_gpio[31:27] !== 5'b11111) begin miscompares++; $display("FAIL eop_collision: got eop=%b st_err_full_eop=%b want 1/11111", c_eop, c_gpio[31:27]); end
    vectors++; if (c_run !== 1'b0 || c_conv !== 1'b0) begin miscompares++; $display("FAIL eop_dropped: got run=%b conv=%b want 0/0", c_run, c_conv); end
    @(negedge clk);
  endtask

  task automatic test_done();
    send(3'd3, 24'h0);
    vectors++; if (c_fsm !== 1'b1 || a_fsm !== 1'b0 || c_gpio[31:30] !== 2'b11) begin miscompares++; $display("FAIL done_req: got v=%b%b st=%b want 10/11", c_fsm, a_fsm, c_gpio[31:30]); end
    @(negedge clk);
    mcu_in = 13'h1ABC;
    #1;
    vectors++; if (gif.o_GPIOdata[12:0] !== 13'h0) begin miscompares++; $display("FAIL mcu_lag: got %h want 0", gif.o_GPIOdata[12:0]); end
    @(negedge clk);
    vectors++; if (gif.o_GPIOdata[26:0] !== 27'h1ABC) begin miscompares++; $display("FAIL mcu_readback: got %h want 1abc", gif.o_GPIOdata[26:0]); end
    send(3'd5, 24'h0);
    vectors++; if (c_gpio[31:27] !== 5'b00010 || c_eop !== 1'b0) begin miscompares++; $display("FAIL done_ack: got %b eop=%b want 00010/0", c_gpio[31:27], c_eop); end
    vectors++; if (c_len !== 10'd1023) begin miscompares++; $display("FAIL len_survives_ack: got %0d want 1023", c_len); end
  endtask

  task automatic test_async_reset();
    send(3'd2, 24'h0);
    send(3'd4, 24'h0);
    vectors++; if (c_run !== 1'b1) begin miscompares++; $display("FAIL rerun: got %b want 1", c_run); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    capture();
    vectors++; if ({c_run, c_kn, c_load, c_eop, c_conv, c_fsm} !== 6'b0 || c_gpio !== 32'h0) begin miscompares++; $display("FAIL async_reset_flags: got %b gpio=%h want 0", {c_run, c_kn, c_load, c_eop, c_conv, c_fsm}, c_gpio); end
    vectors++; if ({c_kdat, c_idx, c_mcu, c_len} !== 44'h0) begin miscompares++; $display("FAIL async_reset_data: got %h want 0", {c_kdat, c_idx, c_mcu, c_len}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_run_no_kernel();
    test_illegal();
    test_kernel();
    test_held_valid();
    test_size();
    test_image();
    test_eop_collision();
    test_done();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
